// File: rtl/scan_decoder_pkg.sv
// Shared encodings and the active-low one-hot helper for the scanning select decoder.
package scan_decoder_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_DIRECT = 2'd2;

    localparam logic MODE_SCAN   = 1'b0;
    localparam logic MODE_DIRECT = 1'b1;

    // Widest select vector the helper can build; bounds SEL_W at 8.
    localparam int unsigned MAX_N = 256;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SCAN   = ST_SCAN,
        S_DIRECT = ST_DIRECT
    } state_e;

    // Bit n-1-idx is low (index 0 lands on the MSB of an n-bit field); all ones if idx >= n.
    function automatic logic [MAX_N-1:0] onehot_n(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        if (idx >= n) return '1;
        return ~(one << (n - 1 - idx));
    endfunction

endpackage

// File: rtl/scan_decoder_tick.sv
// Scan-step prescaler: counts 0..DIV-1 while run is high, tc marks the last count.
module tick_gen
    import scan_decoder_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tc
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tc = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= tc ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered active-low select decoder with direct and auto-scan modes.
//   state  | meaning
//   IDLE   | disabled, all selects inactive, cur_sel held
//   SCAN   | prescaled sweep of channels 0..NUM_CH-1, step_p per advance
//   DIRECT | decode sel_in with one cycle latency
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 8,
    parameter int DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  blank,
    output logic [(1<<SEL_W)-1:0] out_n,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  step_p
);

    localparam int unsigned N = 1 << SEL_W;

    state_e           state_q, state_d;
    logic [N-1:0]     out_n_d;
    logic [SEL_W-1:0] sel_d;
    logic             step_d;
    logic             tick_run, tick_clr, tick_tc;
    logic [MAX_N-1:0] oh;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .run (tick_run),
        .tc  (tick_tc)
    );

    always_comb begin
        state_d = state_q;
        if (!en)                      state_d = S_IDLE;
        else if (mode == MODE_DIRECT) state_d = S_DIRECT;
        else                          state_d = S_SCAN;

        // Prescaler only runs while staying in SCAN, so every entry restarts it.
        tick_run = (state_d == S_SCAN) && (state_q == S_SCAN);
        tick_clr = !tick_run;

        sel_d  = cur_sel;
        step_d = 1'b0;
        case (state_d)
            S_DIRECT: sel_d = sel_in;
            S_SCAN: begin
                if (state_q != S_SCAN) begin
                    if (32'(cur_sel) >= NUM_CH) sel_d = '0;
                end else if (tick_tc) begin
                    step_d = 1'b1;
                    sel_d  = (cur_sel == SEL_W'(NUM_CH - 1)) ? '0 : cur_sel + SEL_W'(1);
                end
            end
            default: ;
        endcase

        oh      = onehot_n(32'(sel_d), N);
        out_n_d = oh[N-1:0];
        if (state_d == S_IDLE || blank || 32'(sel_d) >= NUM_CH) out_n_d = '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_n   <= '1;
            cur_sel <= '0;
            step_p  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_n   <= out_n_d;
            cur_sel <= sel_d;
            step_p  <= step_d;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: three instances (8ch/DIV4, 6ch/DIV4, 8ch/DIV1) against a cycle-age model.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, mode = 1'b0, blank = 1'b0;
    logic [2:0] sel_in = '0;

    logic [7:0] on0, on1, on2;
    logic [2:0] cs0, cs1, cs2;
    logic       sp0, sp1, sp2;

    int n_checks = 0;
    int n_fail   = 0;

    scan_decoder #(.SEL_W(3), .NUM_CH(8), .DIV(4)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .blank(blank),
        .out_n(on0), .cur_sel(cs0), .step_p(sp0));
    scan_decoder #(.SEL_W(3), .NUM_CH(6), .DIV(4)) dut6 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .blank(blank),
        .out_n(on1), .cur_sel(cs1), .step_p(sp1));
    scan_decoder #(.SEL_W(3), .NUM_CH(8), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .blank(blank),
        .out_n(on2), .cur_sel(cs2), .step_p(sp2));

    always #5 clk = ~clk;

    // Model: 0 = off, 1 = scanning (age = cycles since entry), 2 = direct.
    int         m_st[3], m_age[3], m_sel[3];
    logic [7:0] m_out[3];
    logic       m_step[3];

    function automatic int nch(input int i);
        return (i == 1) ? 6 : 8;
    endfunction

    function automatic int dv(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic logic [7:0] sel_pat(input int k);
        return 8'hFF ^ (8'h80 >> k);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_st[i] = 0; m_sel[i] = 0; m_age[i] = 0; m_step[i] = 1'b0; m_out[i] = 8'hFF;
            end else if (!en) begin
                m_st[i] = 0; m_step[i] = 1'b0; m_out[i] = 8'hFF;
            end else if (mode) begin
                m_st[i] = 2; m_step[i] = 1'b0; m_sel[i] = int'(sel_in);
                m_out[i] = (blank || m_sel[i] >= nch(i)) ? 8'hFF : sel_pat(m_sel[i]);
            end else begin
                if (m_st[i] != 1) begin
                    m_age[i] = 0; m_step[i] = 1'b0;
                    if (m_sel[i] >= nch(i)) m_sel[i] = 0;
                end else begin
                    m_age[i]++;
                    m_step[i] = (m_age[i] % dv(i)) == 0;
                    if (m_step[i]) m_sel[i] = (m_sel[i] + 1) % nch(i);
                end
                m_st[i]  = 1;
                m_out[i] = blank ? 8'hFF : sel_pat(m_sel[i]);
            end
        end
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("m8_out",  0, 32'(on0), 32'(m_out[0]));
        check("m8_sel",  0, 32'(cs0), 32'(m_sel[0]));
        check("m8_step", 0, 32'(sp0), 32'(m_step[0]));
        check("m6_out",  1, 32'(on1), 32'(m_out[1]));
        check("m6_sel",  1, 32'(cs1), 32'(m_sel[1]));
        check("m6_step", 1, 32'(sp1), 32'(m_step[1]));
        check("m1_out",  2, 32'(on2), 32'(m_out[2]));
        check("m1_sel",  2, 32'(cs2), 32'(m_sel[2]));
        check("m1_step", 2, 32'(sp2), 32'(m_step[2]));
        check("onehot6", 1, 32'($countones(~on1) <= 1), 32'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b0; blank = 1'b0; sel_in = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst, en, mode, blank;
        logic [2:0] sel;
        logic [7:0] out;
        logic [2:0] cs;
        logic       sp;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic e, input logic m, input logic b, input logic [2:0] s,
                       input logic [7:0] o, input logic [2:0] c, input logic p);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.blank = b; v.sel = s; v.out = o; v.cs = c; v.sp = p;
        vt.push_back(v);
    endtask

    initial begin
        int steps, bad;
        int seq[$];
        logic       s_mode;

        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_age[i] = 0; m_sel[i] = 0; m_out[i] = 8'hFF; m_step[i] = 1'b0;
        end

        // Expected values for the 8-channel DIV=4 instance.
        repeat (3) add(1, 1, 0, 0, 0, 8'hFF, 0, 0);
        repeat (4) add(0, 1, 0, 0, 0, 8'h7F, 0, 0);
        add(0, 1, 0, 0, 0, 8'hBF, 1, 1);
        repeat (3) add(0, 1, 0, 0, 0, 8'hBF, 1, 0);
        add(0, 1, 0, 0, 0, 8'hDF, 2, 1);
        add(0, 1, 1, 0, 5, 8'hFB, 5, 0);
        add(0, 1, 1, 0, 7, 8'hFE, 7, 0);
        add(0, 1, 1, 0, 4, 8'hF7, 4, 0);
        repeat (4) add(0, 1, 0, 0, 0, 8'hF7, 4, 0);
        add(0, 1, 0, 0, 0, 8'hFB, 5, 1);
        add(0, 1, 0, 1, 0, 8'hFF, 5, 0);
        repeat (2) add(0, 0, 0, 0, 0, 8'hFF, 5, 0);
        add(0, 1, 0, 0, 0, 8'hFB, 5, 0);

        foreach (vt[r]) begin
            rst = vt[r].rst; en = vt[r].en; mode = vt[r].mode; blank = vt[r].blank; sel_in = vt[r].sel;
            tick();
            check("tbl_out",  r, 32'(on0), 32'(vt[r].out));
            check("tbl_sel",  r, 32'(cs0), 32'(vt[r].cs));
            check("tbl_step", r, 32'(sp0), 32'(vt[r].sp));
        end

        // Out-of-range direct index on the 6-channel instance.
        mode = 1'b1; sel_in = 3'd7; tick();
        check("dir6_oob_out", 0, 32'(on1), 32'(8'hFF));
        check("dir6_oob_sel", 0, 32'(cs1), 32'(7));

        // Full wrap and reduced-channel sweep from reset.
        do_reset();
        steps = 0; bad = 0;
        for (int age = 0; age <= 32; age++) begin
            tick();
            if (age > 0 && sp0) steps++;
            if (age == 0 || sp1) seq.push_back(int'(cs1));
            if (on1 == 8'hFD || on1 == 8'hFE) bad++;
        end
        check("wrap_steps", 0, 32'(steps), 32'(8));
        check("wrap_out",   0, 32'(on0), 32'(8'h7F));
        check("n6_bad",     0, 32'(bad), 32'(0));
        check("n6_len",     0, 32'(seq.size() >= 7), 32'(1));
        for (int k = 0; k < 7 && k < seq.size(); k++) check("n6_seq", k, 32'(seq[k]), 32'(k % 6));

        // Blank mid-scan at cur_sel=2.
        do_reset();
        repeat (9) tick();
        check("blk_start", 0, 32'(cs0), 32'(2));
        blank = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("blk_out", k, 32'(on0), 32'(8'hFF));
        end
        check("blk_sel", 0, 32'(cs0), 32'(3));
        blank = 1'b0; tick();
        check("blk_rel", 0, 32'(on0), 32'(8'hEF));

        // Disable mid-scan freezes cur_sel.
        en = 1'b0; tick();
        check("dis_out", 0, 32'(on0), 32'(8'hFF));
        check("dis_sel", 0, 32'(cs0), 32'(3));
        repeat (5) tick();
        check("dis_hold", 0, 32'(cs0), 32'(3));

        // Randomised traffic against the model.
        s_mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(19) == 0) s_mode = ~s_mode;
            rst    = ($urandom_range(149) == 0);
            en     = ($urandom_range(11) != 0);
            mode   = s_mode;
            blank  = ($urandom_range(5) == 0);
            sel_in = 3'($urandom_range(7));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered successor to the team's 3-to-8 active-low decoder.
- Drives 2^SEL_W active-low one-hot select lines, for example the digit enables of a multiplexed 7-segment display.
- Two modes:
  - Direct: decodes sel_in.
  - Scan: an internal prescaled counter sweeps channels 0..NUM_CH-1 automatically.
- Sits between the display datapath and the pins; step_p tells the datapath when to present the next digit.

Parameters:
- SEL_W, 3, select index width; output count N = 2^SEL_W.
- NUM_CH, 8, active channels, 1..N; higher indices are never asserted.
- DIV, 4, clock cycles per scan step, >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  block enable; 0 forces IDLE.
- mode  in  1  0 = scan, 1 = direct.
- sel_in  in  SEL_W  direct-mode channel index.
- blank  in  1  forces all outputs inactive without stopping the scan.
- out_n  out  N  active-low one-hot select; channel k drives bit out_n[N-1-k], so k=0 is the MSB.
- cur_sel  out  SEL_W  index currently decoded.
- step_p  out  1  one-cycle pulse in the cycle cur_sel advances in scan mode.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - All outputs are registered.
  - Reset values: out_n = all ones, cur_sel = 0, step_p = 0, prescaler = 0, state = IDLE.
- State machine states: IDLE, SCAN, DIRECT.
  - Any state -> IDLE when en=0.
  - IDLE -> SCAN when en=1 and mode=0.
  - IDLE -> DIRECT when en=1 and mode=1.
  - SCAN <-> DIRECT follows mode whenever en=1; the change takes effect on the next edge.
- IDLE:
  - out_n = all ones, step_p = 0, prescaler held at 0.
  - cur_sel holds its value.
- SCAN:
  - Prescaler counts 0..DIV-1. At DIV-1 it wraps to 0, cur_sel advances, and step_p=1 in the same cycle the new cur_sel appears.
  - cur_sel wraps from NUM_CH-1 to 0.
  - out_n is low only at bit N-1-cur_sel.
  - DIV=1: cur_sel advances every cycle and step_p stays high continuously.
- DIRECT:
  - Latency is one cycle: sel_in sampled at edge t appears on cur_sel and out_n after edge t.
  - If sel_in >= NUM_CH: out_n = all ones and cur_sel takes sel_in.
  - Prescaler is held at 0 and step_p = 0.
- Entering SCAN from IDLE or DIRECT:
  - Prescaler restarts at 0.
  - cur_sel keeps its value, or is forced to 0 if it is >= NUM_CH.
  - The first step happens DIV cycles after entry.
- blank=1:
  - out_n = all ones in the same registered cycle.
  - The prescaler, cur_sel and step_p keep running.
  - Releasing blank restores decoding on the next edge.
- Priority: rst > en=0 > blank > mode.
- Reset mid-scan: the next edge gives the reset values; no partial step_p is emitted.
- Exactly zero or one out_n bit is low in every cycle.

Decomposition:
- Package scan_decoder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DIRECT=2'd2;
  - mode constants MODE_SCAN=1'b0, MODE_DIRECT=1'b1;
  - function onehot_n(idx, N) returning the active-low one-hot vector with MSB = index 0.
- Sub-module tick_gen(DIV): prescaler with clear and run inputs and a terminal-count output.
- The FSM, channel counter and output register stay in scan_decoder.

Test Plan:
- Reset: hold rst=1 for 3 cycles with en=1, mode=0 -> out_n=8'hFF, cur_sel=0, step_p=0 throughout.
- Scan wrap (DIV=4, NUM_CH=8): en=1, mode=0 from reset ->
  - out_n=8'h7F for 4 cycles, then 8'hBF, ..., 8'hFE;
  - then 8'h7F again after 32 cycles;
  - step_p high once every 4 cycles.
- Reduced channels (NUM_CH=6) -> cur_sel sequence 0,1,2,3,4,5,0; out_n never equals 8'hFD or 8'hFE.
- Direct mode: mode=1, sel_in=3'd5 -> next cycle out_n=8'hFB, cur_sel=5. With NUM_CH=6 and sel_in=7 -> out_n=8'hFF.
- Blank mid-scan:
  - assert blank for 6 cycles at cur_sel=2 -> out_n=8'hFF during blank, while cur_sel keeps advancing to 3;
  - release -> out_n=8'hEF.
- Mode switch and disable:
  - DIRECT with sel_in=4, then mode=0 -> cur_sel stays 4 for 4 cycles, then 5.
  - en=0 mid-scan -> out_n=8'hFF next cycle and cur_sel frozen.
